// File: rtl/asip_pkg.sv
// Shared constants and types for the ASIP operand stage: register indices,
// the PC alias index and the registered stage fields.
package asip_pkg;

   localparam int         DATA_W = 18;
   localparam logic [3:0] REG_PC = 4'b1111;

   typedef logic [3:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t   dst;
      logic       wr;
      logic [7:0] ctl;
   } stage_fields_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      stage_fields_t     f;
   } stage_out_t;

endpackage

// File: rtl/operand_scoreboard.sv
// Pending-write scoreboard for R0..R(NREG-1). Index 15 (PC alias) has no bit
// and always reads as not pending.
module operand_scoreboard #(
   parameter int NREG = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set_en,
   input  logic [3:0] set_idx,
   input  logic       clr_en,
   input  logic [3:0] clr_idx,
   input  logic       kill_en,
   input  logic [3:0] kill_idx,
   input  logic [3:0] q1_idx,
   input  logic [3:0] q2_idx,
   input  logic [3:0] q3_idx,
   output logic       q1_pend,
   output logic       q2_pend,
   output logic       q3_pend
);
   import asip_pkg::*;

   logic [NREG-1:0] pend_r;
   logic [NREG-1:0] pend_nxt_s;
   logic [15:0]     pend_ext_s;

   // next pending state: a set on the same edge overrides writeback or kill clears
   always_comb begin
      pend_nxt_s = pend_r;
      for (int i = 0; i < NREG; i++) begin
         if (set_en && (set_idx == reg_idx_t'(i))) begin
            pend_nxt_s[i] = 1'b1;
         end else if ((clr_en && (clr_idx == reg_idx_t'(i))) ||
                      (kill_en && (kill_idx == reg_idx_t'(i)))) begin
            pend_nxt_s[i] = 1'b0;
         end else begin
            pend_nxt_s[i] = pend_r[i];
         end
      end
   end

   // pending bit register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_r <= {NREG{1'b0}};
      end else begin
         pend_r <= pend_nxt_s;
      end
   end

   assign pend_ext_s = 16'(pend_r);
   assign q1_pend    = pend_ext_s[q1_idx];
   assign q2_pend    = pend_ext_s[q2_idx];
   assign q3_pend    = pend_ext_s[q3_idx];

endmodule

// File: rtl/operand_stage.sv
// Operand fetch stage with register scoreboard, hazard stall and one output
// register. Define OPSTAGE_BYPASS_EN to forward same-cycle writeback data.
module operand_stage #(
   parameter int DATA_W = asip_pkg::DATA_W,
   parameter int NREG   = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_src1,
   input  logic [3:0]        in_src2,
   input  logic [3:0]        in_dst,
   input  logic              in_wr,
   input  logic [7:0]        in_ctl,
   output logic [3:0]        ra1,
   output logic [3:0]        ra2,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   input  logic              wb_en,
   input  logic [3:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [3:0]        out_dst,
   output logic              out_wr,
   output logic [7:0]        out_ctl
);
   import asip_pkg::*;

   logic              src1_pend_s, src2_pend_s, dst_pend_s;
   logic              byp1_s, byp2_s;
   logic              hazard_s, accept_s;
   logic              set_en_s, clr_en_s, kill_en_s;
   logic [DATA_W-1:0] opa_s, opb_s;
   logic              out_valid_r;
   logic [DATA_W-1:0] out_a_r, out_b_r;
   stage_fields_t     fields_r;

   assign ra1 = in_src1;
   assign ra2 = in_src2;

`ifdef OPSTAGE_BYPASS_EN
   assign byp1_s = src1_pend_s && wb_en && (wb_addr == in_src1);
   assign byp2_s = src2_pend_s && wb_en && (wb_addr == in_src2);
`else
   logic wb_data_unused_s;
   assign wb_data_unused_s = ^wb_data;
   assign byp1_s           = 1'b0;
   assign byp2_s           = 1'b0;
`endif

   assign opa_s = byp1_s ? wb_data : rd1;
   assign opb_s = byp2_s ? wb_data : rd2;

   assign hazard_s = (src1_pend_s && !byp1_s) || (src2_pend_s && !byp2_s) ||
                     (in_wr && dst_pend_s);
   assign in_ready = !hazard_s && (!out_valid_r || out_ready) && !flush;
   assign accept_s = in_valid && in_ready;

   assign set_en_s  = accept_s && in_wr && (in_dst != REG_PC);
   assign clr_en_s  = wb_en && (wb_addr != REG_PC);
   // a flushed writer will never write back, so release its destination
   assign kill_en_s = flush && out_valid_r && fields_r.wr && (fields_r.dst != REG_PC);

   operand_scoreboard #(
      .NREG (NREG)
   ) u_sb (
      .clk      (clk),
      .reset    (reset),
      .set_en   (set_en_s),
      .set_idx  (in_dst),
      .clr_en   (clr_en_s),
      .clr_idx  (wb_addr),
      .kill_en  (kill_en_s),
      .kill_idx (fields_r.dst),
      .q1_idx   (in_src1),
      .q2_idx   (in_src2),
      .q3_idx   (in_dst),
      .q1_pend  (src1_pend_s),
      .q2_pend  (src2_pend_s),
      .q3_pend  (dst_pend_s)
   );

   // output register: load on accept, drop on flush or drain, else hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_a_r     <= {DATA_W{1'b0}};
         out_b_r     <= {DATA_W{1'b0}};
         fields_r    <= '{dst: 4'h0, wr: 1'b0, ctl: 8'h00};
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         out_a_r     <= opa_s;
         out_b_r     <= opb_s;
         fields_r    <= '{dst: in_dst, wr: in_wr, ctl: in_ctl};
      end else if (flush || out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign out_valid = out_valid_r;
   assign out_a     = out_a_r;
   assign out_b     = out_b_r;
   assign out_dst   = fields_r.dst;
   assign out_wr    = fields_r.wr;
   assign out_ctl   = fields_r.ctl;

endmodule

// File: tb/tb_operand_stage.sv
// Directed scoreboard bench for operand_stage; expectations follow the
// OPSTAGE_BYPASS_EN build setting.
module tb_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [3:0]  in_src1, in_src2, in_dst;
   logic        in_wr;
   logic [7:0]  in_ctl;
   logic [3:0]  ra1, ra2;
   logic [17:0] rd1, rd2;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [17:0] wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [17:0] out_a, out_b;
   logic [3:0]  out_dst;
   logic        out_wr;
   logic [7:0]  out_ctl;

   typedef struct {
      logic [17:0] a;
      logic [17:0] b;
      logic [3:0]  dst;
      logic        wr;
      logic [7:0]  ctl;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_acc = 1'b0;

   operand_stage dut (
      .clk (clk), .reset (reset),
      .in_valid (in_valid), .in_ready (in_ready),
      .in_src1 (in_src1), .in_src2 (in_src2), .in_dst (in_dst),
      .in_wr (in_wr), .in_ctl (in_ctl),
      .ra1 (ra1), .ra2 (ra2), .rd1 (rd1), .rd2 (rd2),
      .wb_en (wb_en), .wb_addr (wb_addr), .wb_data (wb_data),
      .flush (flush),
      .out_valid (out_valid), .out_ready (out_ready),
      .out_a (out_a), .out_b (out_b), .out_dst (out_dst),
      .out_wr (out_wr), .out_ctl (out_ctl)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                        input logic w, input logic [7:0] c,
                        input logic [17:0] r1, input logic [17:0] r2);
      in_valid = 1'b1;
      in_src1  = s1;
      in_src2  = s2;
      in_dst   = d;
      in_wr    = w;
      in_ctl   = c;
      rd1      = r1;
      rd2      = r2;
   endtask

   task automatic expect_out(input logic [17:0] a, input logic [17:0] b, input logic [3:0] d,
                             input logic w, input logic [7:0] c);
      exp_t e;
      e.a   = a;
      e.b   = b;
      e.dst = d;
      e.wr  = w;
      e.ctl = c;
      expq.push_back(e);
   endtask

   task automatic chk_ready(input string name, input logic exp);
      @(negedge clk);
      check(name, 32'(in_ready), 32'(exp));
   endtask

   task automatic chk_zero_outputs(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'h0);
      check({tag, "_a"},     32'(out_a),     32'h0);
      check({tag, "_b"},     32'(out_b),     32'h0);
      check({tag, "_dst"},   32'(out_dst),   32'h0);
      check({tag, "_wr"},    32'(out_wr),    32'h0);
      check({tag, "_ctl"},   32'(out_ctl),   32'h0);
   endtask

   // monitor: the cycle after each accept, the presented output must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (prev_acc) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected: got accept, expected none queued");
         end else begin
            e = expq.pop_front();
            check("mon_valid", 32'(out_valid), 32'h1);
            check("mon_a",     32'(out_a),     32'(e.a));
            check("mon_b",     32'(out_b),     32'(e.b));
            check("mon_dst",   32'(out_dst),   32'(e.dst));
            check("mon_wr",    32'(out_wr),    32'(e.wr));
            check("mon_ctl",   32'(out_ctl),   32'(e.ctl));
         end
      end
      prev_acc = in_valid && in_ready && !reset;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_src1 = 4'd0; in_src2 = 4'd0; in_dst = 4'd0;
      in_wr = 1'b0; in_ctl = 8'h00; rd1 = 18'h0; rd2 = 18'h0; wb_en = 1'b0;
      wb_addr = 4'd0; wb_data = 18'h0; flush = 1'b0; out_ready = 1'b1;
      step(); step();
      @(negedge clk);
      chk_zero_outputs("reset");
      step();
      reset = 1'b0;
      chk_ready("rst_release_ready", 1'b1);
      step();

      // basic issue: R4 becomes pending
      offer(4'd2, 4'd3, 4'd4, 1'b1, 8'hA1, 18'h00011, 18'h00022);
      expect_out(18'h00011, 18'h00022, 4'd4, 1'b1, 8'hA1);
      @(negedge clk);
      check("ra1", 32'(ra1), 32'd2);
      check("ra2", 32'(ra2), 32'd3);
      check("a1_ready", 32'(in_ready), 32'h1);
      step();

      // RAW on R4, resolved by writeback of 0x3FFFF
      offer(4'd4, 4'd0, 4'd7, 1'b0, 8'hB2, 18'h00555, 18'h00033);
      expect_out(18'h3FFFF, 18'h00033, 4'd7, 1'b0, 8'hB2);
      chk_ready("raw_stall0", 1'b0);
      step();
      chk_ready("raw_stall1", 1'b0);
      step();
      wb_en = 1'b1; wb_addr = 4'd4; wb_data = 18'h3FFFF;
`ifdef OPSTAGE_BYPASS_EN
      chk_ready("raw_bypass_ready", 1'b1);
      step();
      wb_en = 1'b0; in_valid = 1'b0; rd1 = 18'h3FFFF;
`else
      chk_ready("raw_wb_cycle_stall", 1'b0);
      step();
      wb_en = 1'b0; rd1 = 18'h3FFFF;
      chk_ready("raw_after_wb_ready", 1'b1);
      step();
      in_valid = 1'b0;
`endif

      // WAW on R5
      offer(4'd0, 4'd1, 4'd5, 1'b1, 8'hC3, 18'h00001, 18'h00002);
      expect_out(18'h00001, 18'h00002, 4'd5, 1'b1, 8'hC3);
      chk_ready("c3_ready", 1'b1);
      step();
      offer(4'd0, 4'd1, 4'd5, 1'b1, 8'hD4, 18'h00010, 18'h00020);
      expect_out(18'h00010, 18'h00020, 4'd5, 1'b1, 8'hD4);
      chk_ready("waw_stall0", 1'b0);
      step();
      chk_ready("waw_stall1", 1'b0);
      step();
      wb_en = 1'b1; wb_addr = 4'd5; wb_data = 18'h00100;
      chk_ready("waw_wb_cycle_stall", 1'b0);
      step();
      wb_en = 1'b0;
      chk_ready("waw_cleared_ready", 1'b1);
      step();

      // backpressure for 3 cycles, then drain and accept on the same edge
      out_ready = 1'b0;
      offer(4'd9, 4'd10, 4'd11, 1'b1, 8'hF6, 18'h00123, 18'h00456);
      expect_out(18'h00123, 18'h00456, 4'd11, 1'b1, 8'hF6);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_ready", 32'(in_ready),  32'h0);
         check("hold_valid", 32'(out_valid), 32'h1);
         check("hold_a",     32'(out_a),     32'h00010);
         check("hold_b",     32'(out_b),     32'h00020);
         check("hold_ctl",   32'(out_ctl),   32'hD4);
         step();
      end
      out_ready = 1'b1;
      chk_ready("drain_ready", 1'b1);
      step();

      // same-edge set and clear of R8: set must win
      offer(4'd0, 4'd0, 4'd8, 1'b1, 8'hE5, 18'h00007, 18'h00008);
      wb_en = 1'b1; wb_addr = 4'd8; wb_data = 18'h00000;
      expect_out(18'h00007, 18'h00008, 4'd8, 1'b1, 8'hE5);
      chk_ready("e5_ready", 1'b1);
      step();
      wb_en = 1'b0;
      offer(4'd8, 4'd0, 4'd0, 1'b0, 8'h00, 18'h00000, 18'h00000);
      chk_ready("set_wins_stall", 1'b0);
      step();
      in_valid = 1'b0; wb_en = 1'b1; wb_addr = 4'd8; wb_data = 18'h00ABC;
      step();
      wb_en = 1'b0;

      // PC sources never stall; flush kills a writer of R6
      offer(4'd15, 4'd15, 4'd6, 1'b1, 8'h17, 18'h3F00F, 18'h00F0F);
      expect_out(18'h3F00F, 18'h00F0F, 4'd6, 1'b1, 8'h17);
      chk_ready("pc_src_ready", 1'b1);
      step();
      in_valid = 1'b0; flush = 1'b1; out_ready = 1'b0;
      chk_ready("flush_ready", 1'b0);
      step();
      flush = 1'b0;
      @(negedge clk);
      check("flush_kill_valid", 32'(out_valid), 32'h0);
      step();
      out_ready = 1'b1;
      offer(4'd6, 4'd15, 4'd12, 1'b0, 8'h28, 18'h00066, 18'h00077);
      expect_out(18'h00066, 18'h00077, 4'd12, 1'b0, 8'h28);
      chk_ready("r6_cleared_ready", 1'b1);
      step();
      offer(4'd15, 4'd2, 4'd15, 1'b1, 8'h3A, 18'h00001, 18'h00002);
      expect_out(18'h00001, 18'h00002, 4'd15, 1'b1, 8'h3A);
      chk_ready("pc_dst_ready0", 1'b1);
      step();
      offer(4'd15, 4'd15, 4'd15, 1'b1, 8'h4B, 18'h00003, 18'h00004);
      expect_out(18'h00003, 18'h00004, 4'd15, 1'b1, 8'h4B);
      chk_ready("pc_dst_ready1", 1'b1);
      step();
      in_valid = 1'b0;

      // asynchronous reset while R1 pending and output held
      offer(4'd0, 4'd0, 4'd1, 1'b1, 8'h5C, 18'h00009, 18'h0000A);
      expect_out(18'h00009, 18'h0000A, 4'd1, 1'b1, 8'h5C);
      chk_ready("g_ready", 1'b1);
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk_zero_outputs("async_rst");
      step(); step();
      reset = 1'b0;
      out_ready = 1'b1;
      offer(4'd1, 4'd5, 4'd11, 1'b1, 8'h6D, 18'h0000B, 18'h0000C);
      expect_out(18'h0000B, 18'h0000C, 4'd11, 1'b1, 8'h6D);
      chk_ready("post_reset_ready", 1'b1);
      step();
      in_valid = 1'b0;
      step(); step();
      check("queue_empty", 32'(expq.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
